// File: rtl/lane_dispatcher.sv
// lane_dispatcher
//   Accepts blocks from one upstream valid/ready stream and hands each block to
//   one of NUM_LANES encryption lanes. Lanes are granted round-robin among the
//   lanes that are ready. Each block is tagged with a running sequence id so the
//   downstream combiner can restore order. The number of blocks dispatched but
//   not yet retired is tracked and capped at MAX_INFLIGHT.
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   enable, flush         run request; stop accepting and drain
//   in_data/valid/ready   upstream block handshake (zero-latency transfer)
//   lane_data/seq_id      in_data and current sequence id broadcast to every lane
//   lane_valid/ready      per-lane handshake; at most one lane_valid bit is high
//   retire                one pulse per block retired by the combiner
//   inflight              blocks dispatched and not yet retired
//   state                 IDLE=0, RUN=1, DRAIN=2
//   busy, err_underflow   activity flag; sticky retire-underflow error
module lane_dispatcher #(
  parameter int BLOCK_WIDTH       = 32,
  parameter int SEQUENCE_ID_WIDTH = 8,
  parameter int NUM_LANES         = 4,
  parameter int MAX_INFLIGHT      = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   enable,
  input  logic                                   flush,
  input  logic [BLOCK_WIDTH-1:0]                 in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [NUM_LANES*BLOCK_WIDTH-1:0]       lane_data,
  output logic [NUM_LANES*SEQUENCE_ID_WIDTH-1:0] lane_seq_id,
  output logic [NUM_LANES-1:0]                   lane_valid,
  input  logic [NUM_LANES-1:0]                   lane_ready,
  input  logic                                   retire,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]      inflight,
  output logic [1:0]                             state,
  output logic                                   busy,
  output logic                                   err_underflow
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int SEQ_W  = SEQUENCE_ID_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
  logic [LANE_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               err_q, err_d;

  logic [LANE_W-1:0]  sel_s;
  logic [LANE_W-1:0]  rr_next_s;
  logic [LANE_W:0]    raw_idx_s;
  logic [LANE_W-1:0]  idx_s;
  logic               any_ready_s;
  logic               accept_ok_s;
  logic               xfer_s;
  logic               drain_done_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush is only looked at while running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = enable ? S_RUN : S_IDLE;
      S_RUN:   state_d = (flush || !enable) ? S_DRAIN : S_RUN;
      S_DRAIN: state_d = (inflight_q == {CNT_W{1'b0}}) ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  // Round-robin lane search: walk offsets high to low so the lowest offset
  // from rr_ptr that is ready wins.
  always_comb begin
    sel_s     = {LANE_W{1'b0}};
    raw_idx_s = {(LANE_W+1){1'b0}};
    idx_s     = {LANE_W{1'b0}};
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      raw_idx_s = {1'b0, rr_ptr_q} + (LANE_W+1)'(i);
      idx_s     = (raw_idx_s >= (LANE_W+1)'(NUM_LANES)) ?
                  LANE_W'(raw_idx_s - (LANE_W+1)'(NUM_LANES)) : LANE_W'(raw_idx_s);
      sel_s     = lane_ready[idx_s] ? idx_s : sel_s;
    end
  end

  // Output logic: handshake, grant decode and status flags.
  always_comb begin
    any_ready_s  = |lane_ready;
    accept_ok_s  = (state_q == S_RUN) && (inflight_q < CNT_W'(MAX_INFLIGHT));
    in_ready     = accept_ok_s && any_ready_s;
    xfer_s       = in_valid && in_ready;
    drain_done_s = (state_q == S_DRAIN) && (inflight_q == {CNT_W{1'b0}});
    busy         = (state_q != S_IDLE) || (inflight_q != {CNT_W{1'b0}});
    rr_next_s    = (sel_s == LANE_W'(NUM_LANES - 1)) ? {LANE_W{1'b0}} : sel_s + LANE_W'(1);
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_valid[k] = xfer_s && (sel_s == LANE_W'(k));
    end
  end

  // Sequence/pointer/in-flight bookkeeping; a retire with nothing in flight
  // and no simultaneous transfer is dropped and flagged.
  always_comb begin
    seq_cnt_d  = seq_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    if (drain_done_s) begin
      seq_cnt_d = {SEQ_W{1'b0}};
      rr_ptr_d  = {LANE_W{1'b0}};
    end else if (xfer_s) begin
      seq_cnt_d = seq_cnt_q + SEQ_W'(1);
      rr_ptr_d  = rr_next_s;
    end else begin
      seq_cnt_d = seq_cnt_q;
      rr_ptr_d  = rr_ptr_q;
    end
    case ({xfer_s, retire})
      2'b10: inflight_d = inflight_q + CNT_W'(1);
      2'b01: begin
        if (inflight_q == {CNT_W{1'b0}}) begin
          err_d = 1'b1;
        end else begin
          inflight_d = inflight_q - CNT_W'(1);
        end
      end
      default: inflight_d = inflight_q;
    endcase
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt_q  <= {SEQ_W{1'b0}};
      rr_ptr_q   <= {LANE_W{1'b0}};
      inflight_q <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      seq_cnt_q  <= seq_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign lane_data     = {NUM_LANES{in_data}};
  assign lane_seq_id   = {NUM_LANES{seq_cnt_q}};
  assign inflight      = inflight_q;
  assign state         = state_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_lane_dispatcher.sv
// Self-checking bench for lane_dispatcher: directed scenarios plus a random
// phase, compared every cycle against a behavioural model. A second instance
// with MAX_INFLIGHT=4 shares the stimulus to exercise the in-flight cap.
module tb_lane_dispatcher;

  localparam int BW = 32;
  localparam int SW = 8;
  localparam int NL = 4;
  localparam int MI = 64;
  localparam int CW = $clog2(MI + 1);
  localparam int CWS = $clog2(4 + 1);

  logic clk = 1'b0;
  logic rst_n, enable, flush, in_valid, retire;
  logic [BW-1:0] in_data;
  logic [NL-1:0] lane_ready;

  logic in_ready, busy, err_underflow;
  logic [NL*BW-1:0] lane_data;
  logic [NL*SW-1:0] lane_seq_id;
  logic [NL-1:0] lane_valid;
  logic [CW-1:0] inflight;
  logic [1:0] state;

  logic s_in_ready, s_busy, s_err;
  logic [NL*BW-1:0] s_lane_data;
  logic [NL*SW-1:0] s_lane_seq_id;
  logic [NL-1:0] s_lane_valid;
  logic [CWS-1:0] s_inflight;
  logic [1:0] s_state;

  int n_assert = 0;
  int n_fail = 0;

  int m_state, m_inflight, m_seq, m_rr;
  bit m_err;

  lane_dispatcher #(.BLOCK_WIDTH(BW), .SEQUENCE_ID_WIDTH(SW), .NUM_LANES(NL), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .lane_data(lane_data), .lane_seq_id(lane_seq_id),
    .lane_valid(lane_valid), .lane_ready(lane_ready),
    .retire(retire), .inflight(inflight), .state(state),
    .busy(busy), .err_underflow(err_underflow));

  lane_dispatcher #(.BLOCK_WIDTH(BW), .SEQUENCE_ID_WIDTH(SW), .NUM_LANES(NL), .MAX_INFLIGHT(4)) u_small (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .lane_data(s_lane_data), .lane_seq_id(s_lane_seq_id),
    .lane_valid(s_lane_valid), .lane_ready(lane_ready),
    .retire(retire), .inflight(s_inflight), .state(s_state),
    .busy(s_busy), .err_underflow(s_err));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First ready lane at or after rr, wrapping; -1 if none ready.
  function automatic int pick(input logic [NL-1:0] rdy, input int rr);
    for (int i = 0; i < NL; i++) begin
      int k;
      k = (rr + i) % NL;
      if (rdy[k[1:0]]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_inflight = 0; m_seq = 0; m_rr = 0; m_err = 1'b0;
  endtask

  // Compare every DUT output with the model, #1 after inputs change.
  task automatic drive_check();
    logic [NL-1:0] elv;
    logic [SW-1:0] s8;
    int s;
    bit rdy;
    #1;
    s = pick(lane_ready, m_rr);
    rdy = (m_state == 1) && (m_inflight < MI) && (s >= 0);
    elv = '0;
    if (rdy && in_valid) elv[s[1:0]] = 1'b1;
    s8 = m_seq[7:0];
    chk("in_ready", 128'(in_ready), 128'(rdy));
    chk("lane_valid", 128'(lane_valid), 128'(elv));
    chk("lane_seq_id", 128'(lane_seq_id), 128'({NL{s8}}));
    chk("lane_data", 128'(lane_data), 128'({NL{in_data}}));
    chk("state", 128'(state), 128'(m_state));
    chk("inflight", 128'(inflight), 128'(m_inflight));
    chk("busy", 128'(busy), 128'((m_state != 0) || (m_inflight != 0)));
    chk("err_underflow", 128'(err_underflow), 128'(m_err));
  endtask

  // Advance one clock and apply the rules to the model; ends at negedge.
  task automatic tick();
    int s, prev;
    bit xfer;
    @(posedge clk);
    s = pick(lane_ready, m_rr);
    xfer = in_valid && (m_state == 1) && (m_inflight < MI) && (s >= 0);
    prev = m_inflight;
    if (xfer && !retire) m_inflight++;
    else if (!xfer && retire) begin
      if (prev == 0) m_err = 1'b1;
      else m_inflight--;
    end
    if (xfer) begin
      m_seq = (m_seq + 1) % 256;
      m_rr = (s + 1) % NL;
    end
    case (m_state)
      0: if (enable) m_state = 1;
      1: if (flush || !enable) m_state = 2;
      2: if (prev == 0) begin m_state = 0; m_seq = 0; m_rr = 0; end
      default: m_state = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic step();
    drive_check();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_lane_valid", 128'(lane_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_inflight", 128'(inflight), 128'(0));
    chk("rst_err", 128'(err_underflow), 128'(0));
    chk("rst_small_inflight", 128'(s_inflight), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; retire = 1'b0;
    in_data = '0; lane_ready = '0;
    #1;
    do_reset();
    step();

    // Six back-to-back blocks, all lanes ready.
    enable = 1'b1; lane_ready = 4'hF;
    step();
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1; in_data = $urandom;
      drive_check();
      chk("s34_lane", 128'(lane_valid), 128'(4'b0001 << (j % 4)));
      chk("s34_seq", 128'(lane_seq_id[7:0]), 128'(j));
      tick();
    end
    in_valid = 1'b0;
    drive_check();
    chk("s34_inflight", 128'(inflight), 128'(6));

    // Move rr_ptr to 1, then ready 1001 grants lane 3 and wraps rr_ptr to 0.
    in_valid = 1'b1; lane_ready = 4'b0001;
    drive_check();
    chk("s35_prep", 128'(lane_valid), 128'(4'b0001));
    tick();
    lane_ready = 4'b1001;
    drive_check();
    chk("s35_lane3", 128'(lane_valid), 128'(4'b1000));
    tick();
    drive_check();
    chk("s35_wrap", 128'(lane_valid), 128'(4'b0001));
    tick();

    // Retire down to 3, then transfer and retire together.
    in_valid = 1'b0; lane_ready = 4'hF; retire = 1'b1;
    for (int j = 0; j < 6; j++) step();
    in_valid = 1'b1;
    step();
    retire = 1'b0; in_valid = 1'b0;
    drive_check();
    chk("s37_inflight", 128'(inflight), 128'(3));

    // Random phase.
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom % 2);
      lane_ready = 4'($urandom);
      retire = (m_inflight > 0) && (($urandom % 2) == 1);
      enable = ($urandom % 16) != 0;
      flush = ($urandom % 40) == 0;
      in_data = $urandom;
      step();
    end

    // Mid-operation reset, then 257 transfers to wrap the sequence id.
    enable = 1'b1; flush = 1'b0; lane_ready = 4'hF; in_valid = 1'b1; retire = 1'b0;
    do_reset();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1; retire = 1'b1;
    for (int j = 0; j < 257; j++) begin
      in_data = $urandom;
      drive_check();
      if (j == 255) chk("s38_seq255", 128'(lane_seq_id[7:0]), 128'(255));
      if (j == 256) chk("s38_seq_wrap", 128'(lane_seq_id[7:0]), 128'(0));
      tick();
    end

    // In-flight cap on the MAX_INFLIGHT=4 instance.
    in_valid = 1'b0; retire = 1'b0;
    do_reset();
    step();
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) step();
    in_valid = 1'b0; retire = 1'b1;
    drive_check();
    chk("s36_full", 128'(s_in_ready), 128'(0));
    tick();
    retire = 1'b0;
    drive_check();
    chk("s36_reopen", 128'(s_in_ready), 128'(1));

    // Flush with two in flight, drain, then an extra retire.
    retire = 1'b1;
    step();
    retire = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b1;
    drive_check();
    chk("s39_drain", 128'(state), 128'(2));
    chk("s39_in_ready", 128'(in_ready), 128'(0));
    chk("s39_lane_valid", 128'(lane_valid), 128'(0));
    tick();
    enable = 1'b0; in_valid = 1'b0; retire = 1'b1;
    step();
    step();
    retire = 1'b0;
    step();
    drive_check();
    chk("s39_idle", 128'(state), 128'(0));
    chk("s39_busy", 128'(busy), 128'(0));
    chk("s39_seq", 128'(lane_seq_id[7:0]), 128'(0));
    retire = 1'b1;
    tick();
    retire = 1'b0;
    drive_check();
    chk("s39_err", 128'(err_underflow), 128'(1));
    tick();

    // enable and flush together in IDLE: RUN first, then DRAIN.
    enable = 1'b1; flush = 1'b1;
    step();
    drive_check();
    chk("s29_run", 128'(state), 128'(1));
    tick();
    enable = 1'b0; flush = 1'b0;
    drive_check();
    chk("s29_drain", 128'(state), 128'(2));
    tick();
    drive_check();
    chk("s29_idle", 128'(state), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
